// File: rtl/ram_pkg.sv
// Shared definitions for the sweep-clear synchronous RAM.
//   state_t     : controller states (clear sweep / idle)
//   DATA_W_DEF  : default word width
//   ADDR_W_DEF  : default address width (depth = 2**ADDR_W_DEF)
package ram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;

endpackage

// File: rtl/ram_sweep_sync_if.sv
// Request/response bundle for ram_sweep_sync.
//   e, w, r, clr, addr, d   : requester -> RAM
//   out, out_valid, busy, rej : RAM -> requester
interface ram_sweep_sync_if
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              e;
  logic              w;
  logic              r;
  logic              clr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              busy;
  logic              rej;

  modport master (
    output e, w, r, clr, addr, d,
    input  out, out_valid, busy, rej
  );

  modport slave (
    input  e, w, r, clr, addr, d,
    output out, out_valid, busy, rej
  );

endinterface

// File: rtl/ram_core.sv
// Storage array with one write port and one registered read port sharing
// a single address.
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we, re   : write / read strobes for this edge
//   addr     : word address
//   wdata    : write data
//   rdata    : registered read data, held between reads
//   rvalid   : high for the cycle after an accepted read
module ram_core
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; zeroing is the sweep's job.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        // Same-edge write: forward new data or return the pre-write word.
        rdata <= (BYPASS && we) ? wdata : mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_sweep_sync.sv
// Single-port synchronous RAM with a zero-fill sweep engine.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : requests (e/w/r/clr/addr/d) in, out/out_valid/busy/rej out
//
// state   | meaning
// S_CLEAR | sweeping zeros through every word, requests rejected
// S_IDLE  | normal read/write access
module ram_sweep_sync
  import ram_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter bit BYPASS        = 1'b1
) (
  input logic             CLK,
  input logic             RST,
  ram_sweep_sync_if.slave bus
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              rej_q, rej_nx;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT_ON_RESET ? S_CLEAR : S_IDLE;
      cnt   <= '0;
      rej_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rej_q <= rej_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rej_nx    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = bus.addr;
    mem_wdata = bus.d;
    unique case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt;
        mem_wdata = '0;
        rej_nx    = bus.e && (bus.w || bus.r);
        if (bus.clr) begin
          cnt_nx = '0;
        end else if (cnt == CNT_LAST) begin
          // Terminal compare instead of a wrap, so the last word is written once.
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        if (bus.clr) begin
          state_nx = S_CLEAR;
          cnt_nx   = '0;
        end else begin
          mem_we = bus.e && bus.w;
          mem_re = bus.e && bus.r;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_core (
    .clk    (CLK),
    .rst    (RST),
    .we     (mem_we),
    .re     (mem_re),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  assign bus.out       = rdata;
  assign bus.out_valid = rvalid;
  assign bus.busy      = (state == S_CLEAR);
  assign bus.rej       = rej_q;

endmodule

// File: tb/tb_ram_sweep_sync.sv
module tb_ram_sweep_sync;

  logic CLK = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  ram_sweep_sync_if #(.DATA_W(16), .ADDR_W(9)) bus_a ();
  ram_sweep_sync_if #(.DATA_W(16), .ADDR_W(9)) bus_b ();
  ram_sweep_sync_if #(.DATA_W(16), .ADDR_W(9)) bus_c ();

  ram_sweep_sync #(.DATA_W(16), .ADDR_W(9), .INIT_ON_RESET(1'b1), .BYPASS(1'b1))
    dut_a (.CLK(CLK), .RST(rst_a), .bus(bus_a));
  ram_sweep_sync #(.DATA_W(16), .ADDR_W(9), .INIT_ON_RESET(1'b1), .BYPASS(1'b0))
    dut_b (.CLK(CLK), .RST(rst_b), .bus(bus_b));
  ram_sweep_sync #(.DATA_W(16), .ADDR_W(9), .INIT_ON_RESET(1'b0), .BYPASS(1'b1))
    dut_c (.CLK(CLK), .RST(rst_c), .bus(bus_c));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv_a(input logic e, input logic w, input logic r, input logic clr,
                       input logic [8:0] a, input logic [15:0] d);
    bus_a.e = e; bus_a.w = w; bus_a.r = r; bus_a.clr = clr; bus_a.addr = a; bus_a.d = d;
  endtask

  task automatic drv_b(input logic e, input logic w, input logic r, input logic clr,
                       input logic [8:0] a, input logic [15:0] d);
    bus_b.e = e; bus_b.w = w; bus_b.r = r; bus_b.clr = clr; bus_b.addr = a; bus_b.d = d;
  endtask

  task automatic drv_c(input logic e, input logic w, input logic r, input logic clr,
                       input logic [8:0] a, input logic [15:0] d);
    bus_c.e = e; bus_c.w = w; bus_c.r = r; bus_c.clr = clr; bus_c.addr = a; bus_c.d = d;
  endtask

  task automatic test_reset();
    int cyc;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000);
    drv_b(0, 0, 0, 0, 9'h000, 16'h0000);
    drv_c(0, 0, 0, 0, 9'h000, 16'h0000);
    tick(); tick();
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_a: got %b expected 1", bus_a.busy); end
    checks++; if (bus_a.out !== 16'h0000) begin errors++; $display("FAIL reset_out_a: got %h expected 0000", bus_a.out); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b expected 0", bus_a.out_valid); end
    checks++; if (bus_a.rej !== 1'b0) begin errors++; $display("FAIL reset_rej_a: got %b expected 0", bus_a.rej); end
    checks++; if (bus_c.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_c: got %b expected 0", bus_c.busy); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    cyc = 0;
    while (bus_a.busy === 1'b1 && cyc < 600) begin tick(); cyc++; end
    checks++; if (cyc !== 512) begin errors++; $display("FAIL init_sweep_len: got %0d cycles expected 512", cyc); end
    checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL init_sweep_b_done: got %b expected 0", bus_b.busy); end
  endtask

  task automatic test_clear_read();
    logic [8:0] addrs [3];
    addrs[0] = 9'h000; addrs[1] = 9'h0FF; addrs[2] = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      drv_a(1, 0, 1, 0, addrs[i], 16'h0000);
      tick();
      checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out !== 16'h0000) begin
        errors++; $display("FAIL clear_read[%0d]: got valid=%b out=%h expected valid=1 out=0000", i, bus_a.out_valid, bus_a.out);
      end
    end
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000);
    tick();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL clear_read_valid_drop: got %b expected 0", bus_a.out_valid); end
  endtask

  task automatic test_write_read();
    drv_a(1, 1, 0, 0, 9'h1FF, 16'hA5A5); tick();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL write_no_valid: got %b expected 0", bus_a.out_valid); end
    drv_a(1, 1, 0, 0, 9'h000, 16'h5A5A); tick();
    drv_a(1, 0, 1, 0, 9'h1FF, 16'h0000); tick();
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out !== 16'hA5A5) begin
      errors++; $display("FAIL read_1ff: got valid=%b out=%h expected valid=1 out=a5a5", bus_a.out_valid, bus_a.out);
    end
    drv_a(1, 0, 1, 0, 9'h000, 16'h0000); tick();
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out !== 16'h5A5A) begin
      errors++; $display("FAIL read_000: got valid=%b out=%h expected valid=1 out=5a5a", bus_a.out_valid, bus_a.out);
    end
    // R and W without E: nothing happens, OUT holds
    drv_a(0, 1, 1, 0, 9'h1FF, 16'h7777); tick();
    checks++; if (bus_a.out_valid !== 1'b0 || bus_a.out !== 16'h5A5A) begin
      errors++; $display("FAIL e_low_hold: got valid=%b out=%h expected valid=0 out=5a5a", bus_a.out_valid, bus_a.out);
    end
    drv_a(1, 0, 1, 0, 9'h1FF, 16'h0000); tick();
    checks++; if (bus_a.out !== 16'hA5A5) begin errors++; $display("FAIL e_low_no_write: got %h expected a5a5", bus_a.out); end
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000); tick();
  endtask

  task automatic test_rdw();
    drv_a(1, 1, 0, 0, 9'h010, 16'h1111);
    drv_b(1, 1, 0, 0, 9'h010, 16'h1111);
    tick();
    drv_a(1, 1, 1, 0, 9'h010, 16'h2222);
    drv_b(1, 1, 1, 0, 9'h010, 16'h2222);
    tick();
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out !== 16'h2222) begin
      errors++; $display("FAIL rdw_bypass: got valid=%b out=%h expected valid=1 out=2222", bus_a.out_valid, bus_a.out);
    end
    checks++; if (bus_b.out_valid !== 1'b1 || bus_b.out !== 16'h1111) begin
      errors++; $display("FAIL rdw_old: got valid=%b out=%h expected valid=1 out=1111", bus_b.out_valid, bus_b.out);
    end
    drv_a(1, 0, 1, 0, 9'h010, 16'h0000);
    drv_b(1, 0, 1, 0, 9'h010, 16'h0000);
    tick();
    checks++; if (bus_a.out !== 16'h2222) begin errors++; $display("FAIL rdw_after_a: got %h expected 2222", bus_a.out); end
    checks++; if (bus_b.out !== 16'h2222) begin errors++; $display("FAIL rdw_after_b: got %h expected 2222", bus_b.out); end
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000);
    drv_b(0, 0, 0, 0, 9'h000, 16'h0000);
    tick();
  endtask

  task automatic test_busy_reject();
    int cyc;
    drv_a(0, 0, 0, 1, 9'h000, 16'h0000); tick();
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b expected 1", bus_a.busy); end
    drv_a(1, 1, 0, 0, 9'h005, 16'hFFFF); tick();
    checks++; if (bus_a.rej !== 1'b1 || bus_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL busy_rej: got rej=%b valid=%b expected rej=1 valid=0", bus_a.rej, bus_a.out_valid);
    end
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000); tick();
    checks++; if (bus_a.rej !== 1'b0) begin errors++; $display("FAIL rej_pulse_width: got %b expected 0", bus_a.rej); end
    cyc = 0;
    while (bus_a.busy === 1'b1 && cyc < 600) begin tick(); cyc++; end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reject_sweep_timeout: got busy=%b expected 0", bus_a.busy); end
    drv_a(1, 0, 1, 0, 9'h005, 16'h0000); tick();
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out !== 16'h0000) begin
      errors++; $display("FAIL reject_no_write: got valid=%b out=%h expected valid=1 out=0000", bus_a.out_valid, bus_a.out);
    end
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000); tick();
  endtask

  task automatic test_clr_restart();
    int cyc;
    drv_a(0, 0, 0, 1, 9'h000, 16'h0000); tick();
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000);
    for (int i = 0; i < 100; i++) tick();
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL restart_mid_busy: got %b expected 1", bus_a.busy); end
    drv_a(0, 0, 0, 1, 9'h000, 16'h0000); tick();
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000);
    cyc = 0;
    while (bus_a.busy === 1'b1 && cyc < 600) begin tick(); cyc++; end
    checks++; if (cyc !== 512) begin errors++; $display("FAIL restart_len: got %0d cycles expected 512", cyc); end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    drv_a(1, 1, 0, 0, 9'h077, 16'hBEEF); tick();
    drv_a(1, 0, 1, 0, 9'h077, 16'h0000); tick();
    checks++; if (bus_a.out !== 16'hBEEF) begin errors++; $display("FAIL pre_reset_read: got %h expected beef", bus_a.out); end
    drv_a(0, 0, 0, 1, 9'h000, 16'h0000); tick();
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000);
    for (int i = 0; i < 50; i++) tick();
    drv_a(1, 0, 1, 0, 9'h077, 16'h0000);
    rst_a = 1'b1; tick();
    checks++; if (bus_a.out !== 16'h0000 || bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b1) begin
      errors++; $display("FAIL mid_sweep_reset: got out=%h valid=%b busy=%b expected 0000 0 1", bus_a.out, bus_a.out_valid, bus_a.busy);
    end
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000);
    rst_a = 1'b0;
    cyc = 0;
    while (bus_a.busy === 1'b1 && cyc < 600) begin tick(); cyc++; end
    checks++; if (cyc !== 512) begin errors++; $display("FAIL post_reset_sweep_len: got %0d cycles expected 512", cyc); end
    drv_a(1, 0, 1, 0, 9'h077, 16'h0000); tick();
    checks++; if (bus_a.out !== 16'h0000 || bus_a.out_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_cleared: got out=%h valid=%b expected 0000 1", bus_a.out, bus_a.out_valid);
    end
    drv_a(0, 0, 0, 0, 9'h000, 16'h0000); tick();
  endtask

  task automatic test_retention();
    drv_c(1, 1, 0, 0, 9'h020, 16'h1234); tick();
    drv_c(1, 0, 1, 0, 9'h020, 16'h0000); tick();
    checks++; if (bus_c.out !== 16'h1234) begin errors++; $display("FAIL ret_pre_read: got %h expected 1234", bus_c.out); end
    drv_c(0, 0, 0, 0, 9'h000, 16'h0000);
    rst_c = 1'b1; tick();
    checks++; if (bus_c.busy !== 1'b0 || bus_c.out !== 16'h0000) begin
      errors++; $display("FAIL ret_reset: got busy=%b out=%h expected 0 0000", bus_c.busy, bus_c.out);
    end
    rst_c = 1'b0; tick();
    checks++; if (bus_c.busy !== 1'b0) begin errors++; $display("FAIL ret_no_busy: got %b expected 0", bus_c.busy); end
    drv_c(1, 0, 1, 0, 9'h020, 16'h0000); tick();
    checks++; if (bus_c.out_valid !== 1'b1 || bus_c.out !== 16'h1234) begin
      errors++; $display("FAIL ret_read: got valid=%b out=%h expected valid=1 out=1234", bus_c.out_valid, bus_c.out);
    end
    drv_c(0, 0, 0, 0, 9'h000, 16'h0000); tick();
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_write_read();
    test_rdw();
    test_busy_reject();
    test_clr_restart();
    test_reset_mid_sweep();
    test_retention();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
